// File: rtl/ltssm_pkg.sv
// Shared LTSSM transmit definitions: ordered-set symbols, the tx_kind word
// tag encoding, the scheduler state enum and the fixed 128-bit ordered-set
// words (symbol 0 in bits [127:120]).
package ltssm_pkg;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_TS   = 2'b01,
    KIND_SKP  = 2'b10,
    KIND_EIOS = 2'b11
  } tx_kind_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    EIOS   = 2'd2,
    EIDLE  = 2'd3
  } sched_state_e;

  localparam logic [127:0] SKP_WORD  = {4{SYM_COM, SYM_SKP, SYM_SKP, SYM_SKP}};
  localparam logic [127:0] EIOS_WORD = {4{SYM_COM, SYM_IDL, SYM_IDL, SYM_IDL}};

endpackage

// File: rtl/skp_timer.sv
// SKP insertion timer. Counts run cycles; every SKP_INTERVAL cycles it adds
// one pending SKP to a 2-bit saturating count. An add attempted at 3 sets the
// sticky overflow flag instead.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   run       - count this cycle (scheduler is ACTIVE); low holds count at 0
//   clr       - clear interval counter and pending count
//   take      - one pending SKP is being emitted this cycle
//   skp_pend  - pending SKP words (0..3)
//   skp_ovf   - sticky: a SKP was lost to saturation; cleared only by rst
module skp_timer #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  input  logic       take,
  output logic [1:0] skp_pend,
  output logic       skp_ovf
);

  localparam int            TW   = $clog2(SKP_INTERVAL);
  localparam logic [TW-1:0] LAST = TW'(SKP_INTERVAL - 1);

  logic [TW-1:0] tmr;
  logic          wrap;

  assign wrap = (tmr == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr      <= '0;
      skp_pend <= 2'd0;
      skp_ovf  <= 1'b0;
    end else if (clr || !run) begin
      tmr      <= '0;
      skp_pend <= 2'd0;
    end else begin
      tmr <= wrap ? '0 : tmr + 1'b1;
      // A wrap and an emission in the same cycle cancel out.
      if (wrap && !take) begin
        if (skp_pend == 2'd3) skp_ovf  <= 1'b1;
        else                  skp_pend <= skp_pend + 2'd1;
      end else if (take && !wrap) begin
        skp_pend <= skp_pend - 2'd1;
      end
    end
  end

endmodule

// File: rtl/tx_os_sched.sv
// Transmit ordered-set scheduler. Shares the 128-bit TX FIFO write port
// between EIOS (highest), periodic SKP and ts_gen training sequences, and
// throttles ts_gen with a combinational hold so an accepted TS is always
// written.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   sched_en      - transmitter enable level from LTSSM
//   eios_req      - request electrical idle (honoured in ACTIVE only)
//   ts_valid, ts  - TS word offered by ts_gen
//   tx_fifo_full  - FIFO full (still has one free entry of slack)
//   gen_hold      - combinational hold back to ts_gen
//   tx_valid, tx_data, tx_kind - registered FIFO write
//   eios_done     - pulse with the last EIOS word
//   skp_ovf       - sticky SKP pending-count overflow
module tx_os_sched
  import ltssm_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int EIOS_REPEAT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sched_en,
  input  logic         eios_req,
  input  logic         ts_valid,
  input  logic [127:0] ts,
  input  logic         tx_fifo_full,
  output logic         gen_hold,
  output logic         tx_valid,
  output logic [127:0] tx_data,
  output logic [1:0]   tx_kind,
  output logic         eios_done,
  output logic         skp_ovf
);

  localparam logic [3:0] EIOS_LAST = 4'(EIOS_REPEAT - 1);

  sched_state_e state, state_nxt;
  logic [3:0]   eios_cnt;
  logic [1:0]   skp_pend;
  logic         run, clr, take;

  logic         vld_p0;
  logic         last_p0;
  tx_kind_e     kind_p0;
  logic [127:0] data_p0;

  assign gen_hold = tx_fifo_full | (state != ACTIVE) | (skp_pend != 2'd0) | eios_req;

  // The timer is held at zero outside ACTIVE, so the clear on entry to ACTIVE
  // and the discard on entry to EIOS both fall out of run going low.
  assign run = (state == ACTIVE);
  assign clr = (state == IDLE) && sched_en;

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .clr     (clr),
    .take    (take),
    .skp_pend(skp_pend),
    .skp_ovf (skp_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: state transition and word selection
  always_comb begin
    state_nxt = state;
    vld_p0    = 1'b0;
    last_p0   = 1'b0;
    kind_p0   = KIND_NONE;
    data_p0   = '0;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (sched_en) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!tx_fifo_full) begin
          if (skp_pend != 2'd0) begin
            vld_p0  = 1'b1;
            kind_p0 = KIND_SKP;
            data_p0 = SKP_WORD;
            take    = 1'b1;
          end else if (ts_valid && !gen_hold) begin
            vld_p0  = 1'b1;
            kind_p0 = KIND_TS;
            data_p0 = ts;
          end
        end
        if (eios_req)       state_nxt = EIOS;
        else if (!sched_en) state_nxt = IDLE;
      end
      EIOS: begin
        if (!tx_fifo_full) begin
          vld_p0  = 1'b1;
          kind_p0 = KIND_EIOS;
          data_p0 = EIOS_WORD;
          last_p0 = (eios_cnt == EIOS_LAST);
          if (last_p0) state_nxt = EIDLE;
        end
      end
      EIDLE: begin
        if (!sched_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                eios_cnt <= 4'd0;
    else if ((state == ACTIVE) && eios_req) eios_cnt <= 4'd0;
    else if ((state == EIOS) && vld_p0)     eios_cnt <= eios_cnt + 4'd1;
  end

  // Stage p1: registered FIFO write; reset drops any word selected this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid  <= 1'b0;
      tx_kind   <= KIND_NONE;
      tx_data   <= '0;
      eios_done <= 1'b0;
    end else begin
      tx_valid  <= vld_p0;
      tx_kind   <= kind_p0;
      tx_data   <= data_p0;
      eios_done <= last_p0;
    end
  end

endmodule
